// File: rtl/csrng_cmd_collector_pkg.sv
// Shared types for the CSRNG application command collector: command header
// layout, application commands, command status and collector FSM encoding.
package csrng_cmd_collector_pkg;

  localparam int unsigned CsKeymgrDivWidth    = 384;
  localparam int unsigned CollectorAdataWidth = CsKeymgrDivWidth;
  localparam int unsigned CollectorAdataWords = CollectorAdataWidth / 32;
  localparam int unsigned GenBitsWidth        = 128;
  localparam int unsigned CmdGlenWidth        = 12;

  typedef enum logic [2:0] {
    INV  = 3'h0,
    INS  = 3'h1,
    RES  = 3'h2,
    GEN  = 3'h3,
    UPD  = 3'h4,
    UNI  = 3'h5,
    GENB = 3'h6,
    GENU = 3'h7
  } acmd_e;

  typedef enum logic [2:0] {
    CMD_STS_SUCCESS             = 3'h0,
    CMD_STS_INVALID_ACMD        = 3'h1,
    CMD_STS_INVALID_GEN_CMD     = 3'h2,
    CMD_STS_INVALID_CMD_SEQ     = 3'h3,
    CMD_STS_RESEED_CNT_EXCEEDED = 3'h4
  } csrng_cmd_sts_e;

  typedef struct packed {
    logic [7:0]              rsvd_hi;
    logic [CmdGlenWidth-1:0] glen;
    logic [3:0]              flag0;
    logic [3:0]              clen;
    logic                    rsvd_lo;
    acmd_e                   acmd;
  } csrng_cmd_t;

  // Pairwise Hamming distance >= 3 so a single upset never lands in a valid state.
  typedef enum logic [5:0] {
    COLL_IDLE  = 6'b000000,
    COLL_ADATA = 6'b000111,
    COLL_CHECK = 6'b011001,
    COLL_ISSUE = 6'b011110,
    COLL_WAIT  = 6'b101010,
    COLL_ACK   = 6'b101101,
    COLL_ERROR = 6'b110011
  } collector_sm_state_e;

  function automatic logic acmd_is_illegal(acmd_e acmd);
    return acmd inside {INV, GENB, GENU};
  endfunction

endpackage

// File: rtl/csrng_genbits_skid.sv
// One-entry skid register between the CSRNG core and the application for
// generated blocks (data + FIPS flag); full throughput, one cycle latency.
module csrng_genbits_skid #(
  parameter int unsigned Width = 129
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic [Width-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [Width-1:0] out_data_o,
  input  logic             out_ready_i
);

  logic             full_q;
  logic [Width-1:0] data_q;

  assign in_ready_o  = !full_q || out_ready_i;
  assign out_valid_o = full_q;
  assign out_data_o  = data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (in_valid_i && in_ready_o) begin
      full_q <= 1'b1;
      data_q <= in_data_i;
    end else if (out_ready_i) begin
      full_q <= 1'b0;
    end
  end

endmodule

// File: rtl/csrng_cmd_collector.sv
// Application-side CSRNG command front end: parses header + adata, issues one
// command to the core, forwards generated blocks and returns one ack per command.
module csrng_cmd_collector
  import csrng_cmd_collector_pkg::*;
#(
  parameter int unsigned AdataMaxWords = 12,
  parameter int unsigned GlenWidth     = 12
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           enable_i,
  input  logic                           cmd_req_valid_i,
  input  logic [31:0]                    cmd_req_bus_i,
  output logic                           cmd_req_ready_o,
  output logic                           core_req_valid_o,
  input  logic                           core_req_ready_i,
  output logic [2:0]                     core_acmd_o,
  output logic [3:0]                     core_clen_o,
  output logic [3:0]                     core_flag0_o,
  output logic [GlenWidth-1:0]           core_glen_o,
  output logic [CollectorAdataWidth-1:0] core_adata_o,
  input  logic                           core_done_i,
  input  logic [2:0]                     core_sts_i,
  input  logic                           core_genbits_valid_i,
  input  logic [GenBitsWidth-1:0]        core_genbits_i,
  input  logic                           core_genbits_fips_i,
  output logic                           core_genbits_ready_o,
  output logic                           genbits_valid_o,
  output logic [GenBitsWidth-1:0]        genbits_bus_o,
  output logic                           genbits_fips_o,
  input  logic                           genbits_ready_i,
  output logic                           rsp_ack_o,
  output logic [2:0]                     rsp_sts_o,
  output logic                           err_o
);

  localparam logic [3:0] ClenMax = 4'(AdataMaxWords);

  collector_sm_state_e state_q, state_d;
  csrng_cmd_sts_e      sts_q, sts_d;
  acmd_e               acmd_q;
  logic [3:0]          clen_q, flag0_q, wcnt_q;
  logic [GlenWidth-1:0] glen_q, bcnt_q, ccnt_q, bcnt_now;
  logic [CollectorAdataWords-1:0][31:0] adata_q;
  logic                done_seen_q, done_now;
  csrng_cmd_sts_e      sts_now;

  csrng_cmd_t hdr;
  logic       unused_hdr;
  logic       cmd_accept, gen_active, blocks_pending;
  logic       core_hs, app_hs, skid_in_ready, skid_in_valid, skid_flush;

  assign hdr        = csrng_cmd_t'(cmd_req_bus_i);
  assign unused_hdr = ^{hdr.rsvd_hi, hdr.rsvd_lo};
  assign cmd_accept = cmd_req_valid_i && cmd_req_ready_o;

  // Genbits path is live only while a GEN waits on the core; core side is
  // throttled by blocks accepted so far, so nothing beyond glen is pulled.
  assign gen_active           = enable_i && (state_q == COLL_WAIT) && (acmd_q == GEN);
  assign blocks_pending       = (ccnt_q != glen_q);
  assign skid_in_valid        = core_genbits_valid_i && gen_active && blocks_pending;
  assign core_genbits_ready_o = gen_active && blocks_pending && skid_in_ready;
  assign skid_flush           = !enable_i || (state_q != COLL_WAIT);
  assign core_hs              = core_genbits_valid_i && core_genbits_ready_o;
  assign app_hs               = genbits_valid_o && genbits_ready_i;

  csrng_genbits_skid #(
    .Width(GenBitsWidth + 1)
  ) u_skid (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .flush_i    (skid_flush),
    .in_valid_i (skid_in_valid),
    .in_data_i  ({core_genbits_fips_i, core_genbits_i}),
    .in_ready_o (skid_in_ready),
    .out_valid_o(genbits_valid_o),
    .out_data_o ({genbits_fips_o, genbits_bus_o}),
    .out_ready_i(genbits_ready_i)
  );

  assign done_now = done_seen_q || core_done_i;
  assign sts_now  = core_done_i ? csrng_cmd_sts_e'(core_sts_i) : sts_q;
  assign bcnt_now = bcnt_q + GlenWidth'(app_hs);

  always_comb begin
    state_d          = state_q;
    sts_d            = sts_q;
    cmd_req_ready_o  = 1'b0;
    core_req_valid_o = 1'b0;
    rsp_ack_o        = 1'b0;
    if (!enable_i) begin
      state_d = COLL_IDLE;
    end else begin
      case (state_q)
        COLL_IDLE: begin
          cmd_req_ready_o = 1'b1;
          if (cmd_req_valid_i) begin
            sts_d = CMD_STS_SUCCESS;
            if (hdr.clen > ClenMax) begin
              state_d = COLL_ERROR;
            end else if (hdr.clen == 4'd0) begin
              state_d = COLL_CHECK;
            end else begin
              state_d = COLL_ADATA;
            end
          end
        end
        COLL_ADATA: begin
          cmd_req_ready_o = 1'b1;
          if (cmd_req_valid_i && (wcnt_q == clen_q - 4'd1)) begin
            state_d = COLL_CHECK;
          end
        end
        COLL_CHECK: begin
          if (acmd_is_illegal(acmd_q)) begin
            sts_d   = CMD_STS_INVALID_ACMD;
            state_d = COLL_ACK;
          end else if ((acmd_q == GEN) && (glen_q == '0)) begin
            sts_d   = CMD_STS_INVALID_GEN_CMD;
            state_d = COLL_ACK;
          end else begin
            state_d = COLL_ISSUE;
          end
        end
        COLL_ISSUE: begin
          core_req_valid_o = 1'b1;
          if (core_req_ready_i) begin
            state_d = COLL_WAIT;
          end
        end
        COLL_WAIT: begin
          sts_d = sts_now;
          if (done_now && ((sts_now != CMD_STS_SUCCESS) || (acmd_q != GEN) ||
                           (bcnt_now == glen_q))) begin
            state_d = COLL_ACK;
          end
        end
        COLL_ACK: begin
          rsp_ack_o = 1'b1;
          state_d   = COLL_IDLE;
        end
        COLL_ERROR: begin
          state_d = COLL_ERROR;
        end
        default: begin
          state_d = COLL_ERROR;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || !enable_i) begin
      state_q     <= COLL_IDLE;
      sts_q       <= CMD_STS_SUCCESS;
      acmd_q      <= INV;
      clen_q      <= '0;
      flag0_q     <= '0;
      glen_q      <= '0;
      wcnt_q      <= '0;
      bcnt_q      <= '0;
      ccnt_q      <= '0;
      adata_q     <= '0;
      done_seen_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sts_q   <= sts_d;
      if ((state_q == COLL_IDLE) && cmd_accept) begin
        acmd_q      <= hdr.acmd;
        clen_q      <= hdr.clen;
        flag0_q     <= hdr.flag0;
        glen_q      <= GlenWidth'(hdr.glen);
        adata_q     <= '0;
        wcnt_q      <= '0;
        bcnt_q      <= '0;
        ccnt_q      <= '0;
        done_seen_q <= 1'b0;
      end
      if ((state_q == COLL_ADATA) && cmd_accept) begin
        adata_q[wcnt_q] <= cmd_req_bus_i;
        wcnt_q          <= wcnt_q + 4'd1;
      end
      if (state_q == COLL_WAIT) begin
        if (core_done_i) begin
          done_seen_q <= 1'b1;
        end
        if (app_hs) begin
          bcnt_q <= bcnt_q + GlenWidth'(1);
        end
        if (core_hs) begin
          ccnt_q <= ccnt_q + GlenWidth'(1);
        end
      end
    end
  end

  assign core_acmd_o  = acmd_q;
  assign core_clen_o  = clen_q;
  assign core_flag0_o = flag0_q;
  assign core_glen_o  = glen_q;
  assign core_adata_o = adata_q;
  assign rsp_sts_o    = sts_q;
  assign err_o        = (state_q == COLL_ERROR);

endmodule

// File: tb/tb_csrng_cmd_collector.sv
// Scoreboard bench for csrng_cmd_collector: directed commands push expected
// core requests, blocks and acks; a negedge monitor pops and compares them.
module tb_csrng_cmd_collector;

  localparam logic [2:0] A_INV = 3'd0, A_INS = 3'd1, A_GEN = 3'd3, A_UNI = 3'd5;

  typedef struct {
    logic [2:0]   acmd;
    logic [3:0]   clen;
    logic [3:0]   flag0;
    logic [11:0]  glen;
    logic [383:0] adata;
  } req_t;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         enable_i = 1'b1;
  logic         cmd_req_valid_i = 1'b0;
  logic [31:0]  cmd_req_bus_i = '0;
  logic         cmd_req_ready_o;
  logic         core_req_valid_o;
  logic         core_req_ready_i = 1'b0;
  logic [2:0]   core_acmd_o;
  logic [3:0]   core_clen_o;
  logic [3:0]   core_flag0_o;
  logic [11:0]  core_glen_o;
  logic [383:0] core_adata_o;
  logic         core_done_i = 1'b0;
  logic [2:0]   core_sts_i = '0;
  logic         core_genbits_valid_i = 1'b0;
  logic [127:0] core_genbits_i = '0;
  logic         core_genbits_fips_i = 1'b0;
  logic         core_genbits_ready_o;
  logic         genbits_valid_o;
  logic [127:0] genbits_bus_o;
  logic         genbits_fips_o;
  logic         genbits_ready_i = 1'b1;
  logic         rsp_ack_o;
  logic [2:0]   rsp_sts_o;
  logic         err_o;

  int checks = 0;
  int errors = 0;
  logic app_toggle = 1'b0;

  req_t         exp_req[$];
  logic [128:0] exp_gen[$];
  logic [2:0]   exp_ack[$];

  always #5 clk = ~clk;

  csrng_cmd_collector #(
    .AdataMaxWords(12),
    .GlenWidth    (12)
  ) dut (
    .clk_i               (clk),
    .rst_i               (rst_i),
    .enable_i            (enable_i),
    .cmd_req_valid_i     (cmd_req_valid_i),
    .cmd_req_bus_i       (cmd_req_bus_i),
    .cmd_req_ready_o     (cmd_req_ready_o),
    .core_req_valid_o    (core_req_valid_o),
    .core_req_ready_i    (core_req_ready_i),
    .core_acmd_o         (core_acmd_o),
    .core_clen_o         (core_clen_o),
    .core_flag0_o        (core_flag0_o),
    .core_glen_o         (core_glen_o),
    .core_adata_o        (core_adata_o),
    .core_done_i         (core_done_i),
    .core_sts_i          (core_sts_i),
    .core_genbits_valid_i(core_genbits_valid_i),
    .core_genbits_i      (core_genbits_i),
    .core_genbits_fips_i (core_genbits_fips_i),
    .core_genbits_ready_o(core_genbits_ready_o),
    .genbits_valid_o     (genbits_valid_o),
    .genbits_bus_o       (genbits_bus_o),
    .genbits_fips_o      (genbits_fips_o),
    .genbits_ready_i     (genbits_ready_i),
    .rsp_ack_o           (rsp_ack_o),
    .rsp_sts_o           (rsp_sts_o),
    .err_o               (err_o)
  );

  task automatic check(input string name, input logic [383:0] act, input logic [383:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] hdr(input logic [2:0] acmd, input logic [3:0] clen,
                                      input logic [3:0] flag0, input logic [11:0] glen);
    return {8'h00, glen, flag0, clen, 1'b0, acmd};
  endfunction

  task automatic push_req(input logic [2:0] acmd, input logic [3:0] clen,
                          input logic [3:0] flag0, input logic [11:0] glen,
                          input logic [383:0] adata);
    req_t r;
    r.acmd = acmd; r.clen = clen; r.flag0 = flag0; r.glen = glen; r.adata = adata;
    exp_req.push_back(r);
  endtask

  task automatic send_word(input logic [31:0] w);
    int n = 0;
    cmd_req_valid_i = 1'b1;
    cmd_req_bus_i   = w;
    @(negedge clk);
    while (!cmd_req_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_word_timeout", 1'b1, 1'b0 ^ (n < 200));
    @(posedge clk); #1;
    cmd_req_valid_i = 1'b0;
  endtask

  // Returns at the negedge where the core request handshake is visible.
  task automatic wait_req_hs(input int stall);
    int n = 0;
    @(negedge clk);
    while (!core_req_valid_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("req_seen", core_req_valid_o, 1'b1);
    if (core_req_valid_o && !core_req_ready_i) begin
      repeat (stall) @(posedge clk);
      #1 core_req_ready_i = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic push_block(input logic [127:0] d, input logic f);
    int n = 0;
    core_genbits_valid_i = 1'b1;
    core_genbits_i       = d;
    core_genbits_fips_i  = f;
    @(negedge clk);
    while (!core_genbits_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("core_block_taken", core_genbits_ready_o, 1'b1);
    @(posedge clk); #1;
    core_genbits_valid_i = 1'b0;
  endtask

  task automatic pulse_done(input logic [2:0] sts);
    core_done_i = 1'b1;
    core_sts_i  = sts;
    @(posedge clk); #1;
    core_done_i = 1'b0;
    core_sts_i  = '0;
  endtask

  task automatic wait_ack();
    int n = 0;
    @(negedge clk);
    while (!rsp_ack_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ack_seen", rsp_ack_o, 1'b1);
  endtask

  // Scoreboard monitor: every DUT output event must match the head of its queue.
  initial begin
    req_t r;
    logic [128:0] g;
    logic [2:0] s;
    forever begin
      @(negedge clk);
      if (core_req_valid_o && core_req_ready_i) begin
        check("req_expected", exp_req.size() != 0, 1'b1);
        if (exp_req.size() != 0) begin
          r = exp_req.pop_front();
          check("req_acmd", core_acmd_o, r.acmd);
          check("req_clen", core_clen_o, r.clen);
          check("req_flag0", core_flag0_o, r.flag0);
          check("req_glen", core_glen_o, r.glen);
          check("req_adata", core_adata_o, r.adata);
        end
      end
      if (genbits_valid_o && genbits_ready_i) begin
        check("gen_expected", exp_gen.size() != 0, 1'b1);
        if (exp_gen.size() != 0) begin
          g = exp_gen.pop_front();
          check("gen_block", {genbits_fips_o, genbits_bus_o}, g);
        end
      end
      if (rsp_ack_o) begin
        check("ack_expected", exp_ack.size() != 0, 1'b1);
        check("ack_after_blocks", exp_gen.size(), 0);
        if (exp_ack.size() != 0) begin
          s = exp_ack.pop_front();
          check("ack_sts", rsp_sts_o, s);
        end
      end
    end
  end

  initial begin
    logic [127:0] blk;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_core_valid", core_req_valid_o, 1'b0);
    check("rst_gen_valid", genbits_valid_o, 1'b0);
    check("rst_ack", rsp_ack_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    check("rst_sts", rsp_sts_o, 3'd0);
    check("rst_adata", core_adata_o, 384'd0);
    check("rst_genbus", genbits_bus_o, 128'd0);
    check("rst_glen", core_glen_o, 12'd0);
    @(posedge clk); #1 rst_i = 1'b0;
    @(negedge clk);
    check("idle_ready", cmd_req_ready_o, 1'b1);
    @(posedge clk); #1;

    // INS, clen=2, core stalls request ready for two cycles
    push_req(A_INS, 4'd2, 4'd0, 12'd0, {320'd0, 32'h5A5A5A5A, 32'hA5A5A5A5});
    exp_ack.push_back(3'd0);
    send_word(hdr(A_INS, 4'd2, 4'd0, 12'd0));
    send_word(32'hA5A5A5A5);
    send_word(32'h5A5A5A5A);
    wait_req_hs(2);
    @(posedge clk); #1;
    pulse_done(3'd0);
    wait_ack();
    @(posedge clk); #1;
    @(negedge clk);
    check("ins_ack_single", rsp_ack_o, 1'b0);
    check("ins_ready_after_ack", cmd_req_ready_o, 1'b1);
    @(posedge clk); #1;

    // GEN glen=3 with application ready toggling every cycle
    push_req(A_GEN, 4'd0, 4'd0, 12'd3, 384'd0);
    for (int i = 0; i < 3; i++) exp_gen.push_back({1'b1, {4{32'hC0DE_0000 + 32'(i)}}});
    exp_ack.push_back(3'd0);
    app_toggle = 1'b1;
    fork
      while (app_toggle) begin
        @(posedge clk); #1;
        if (app_toggle) genbits_ready_i = !genbits_ready_i;
      end
    join_none
    send_word(hdr(A_GEN, 4'd0, 4'd0, 12'd3));
    wait_req_hs(0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      blk = {4{32'hC0DE_0000 + 32'(i)}};
      push_block(blk, 1'b1);
    end
    pulse_done(3'd0);
    wait_ack();
    app_toggle = 1'b0;
    @(posedge clk); #2;
    genbits_ready_i = 1'b1;
    check("gen_all_delivered", exp_gen.size(), 0);

    // INV with clen=1: word drained, no core request, sts 1
    exp_ack.push_back(3'd1);
    send_word(hdr(A_INV, 4'd1, 4'd0, 12'd0));
    send_word(32'hDEADBEEF);
    wait_ack();
    @(posedge clk); #1;

    // GEN with glen=0: no core request, sts 2
    exp_ack.push_back(3'd2);
    send_word(hdr(A_GEN, 4'd0, 4'd0, 12'd0));
    wait_ack();
    @(posedge clk); #1;

    // clen=13: sticky error until enable drops
    send_word(hdr(A_INS, 4'd13, 4'd0, 12'd0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("err_sticky", err_o, 1'b1);
      check("err_ready", cmd_req_ready_o, 1'b0);
      check("err_core_valid", core_req_valid_o, 1'b0);
    end
    @(posedge clk); #1 enable_i = 1'b0;
    @(negedge clk);
    check("disabled_ready", cmd_req_ready_o, 1'b0);
    @(posedge clk); #1 enable_i = 1'b1;
    @(negedge clk);
    check("err_cleared", err_o, 1'b0);
    check("err_exit_ready", cmd_req_ready_o, 1'b1);
    @(posedge clk); #1;

    // GEN glen=4 aborted by enable low after two blocks reach the application
    push_req(A_GEN, 4'd0, 4'd0, 12'd4, 384'd0);
    for (int i = 0; i < 2; i++) exp_gen.push_back({1'b0, {4{32'hB10C_0000 + 32'(i)}}});
    send_word(hdr(A_GEN, 4'd0, 4'd0, 12'd4));
    wait_req_hs(0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      blk = {4{32'hB10C_0000 + 32'(i)}};
      push_block(blk, 1'b0);
    end
    enable_i        = 1'b0;
    genbits_ready_i = 1'b0;
    @(negedge clk);
    check("abort_pending_block", genbits_valid_o, 1'b1);
    @(posedge clk); #1 enable_i = 1'b1;
    @(negedge clk);
    check("abort_flushed", genbits_valid_o, 1'b0);
    check("abort_no_ack", rsp_ack_o, 1'b0);
    check("abort_idle", cmd_req_ready_o, 1'b1);
    check("abort_blocks", exp_gen.size(), 0);
    genbits_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // UNI after abort; done in the first Wait cycle gives ack two cycles after issue
    push_req(A_UNI, 4'd0, 4'd3, 12'd0, 384'd0);
    exp_ack.push_back(3'd0);
    send_word(hdr(A_UNI, 4'd0, 4'd3, 12'd0));
    wait_req_hs(0);
    @(posedge clk); #1;
    pulse_done(3'd0);
    @(negedge clk);
    check("uni_ack_latency", rsp_ack_o, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);

    check("end_req_queue", exp_req.size(), 0);
    check("end_gen_queue", exp_gen.size(), 0);
    check("end_ack_queue", exp_ack.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
